// File: rtl/mips_cpu_hilo_reg_pkg.sv
// Shared CPU constants for the HI/LO special-register pair.
package mips_cpu_hilo_reg_pkg;

  // Architectural data width of HI, LO and the general register file.
  localparam int unsigned DATA_W = 32;

  // Value HI and LO take while reset is asserted.
  localparam logic [DATA_W-1:0] HILO_RESET_VAL = DATA_W'(0);

  // HI/LO pair as one payload, e.g. for a multiply/divide result bus.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

endpackage : mips_cpu_hilo_reg_pkg

// File: rtl/mips_cpu_en_reg.sv
// Generic WIDTH-bit register with a write enable and async active-low reset.
// A deasserted enable holds the stored value regardless of the data input.
module mips_cpu_en_reg
  import mips_cpu_hilo_reg_pkg::*;
#(
  parameter int unsigned       WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(0)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: load on enable, otherwise hold (data never leaks when en_i==0).
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  // State register; reset clears immediately and blocks any write while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : mips_cpu_en_reg

// File: rtl/mips_cpu_hilo_reg.sv
// HI/LO special-register pair: written at write-back by MULT/DIV/MTHI/MTLO,
// read by MFHI/MFLO. Reads come straight from the stored state, no bypass,
// so a write at edge N becomes visible just after edge N.
module mips_cpu_hilo_reg
  import mips_cpu_hilo_reg_pkg::*;
#(
  parameter int unsigned       WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(HILO_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_hi,
  input  logic [WIDTH-1:0] data_lo,
  input  logic             hi_en,
  input  logic             lo_en,
  output logic [WIDTH-1:0] read_hi,
  output logic [WIDTH-1:0] read_lo
);

  // HI register.
  mips_cpu_en_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_hi_reg (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (hi_en),
    .d_i   (data_hi),
    .q_o   (read_hi)
  );

  // LO register.
  mips_cpu_en_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_lo_reg (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (lo_en),
    .d_i   (data_lo),
    .q_o   (read_lo)
  );

endmodule : mips_cpu_hilo_reg

// File: tb/tb_mips_cpu_hilo_reg.sv
// Scoreboard bench for mips_cpu_hilo_reg: stimulus pushes expected HI/LO
// values, a separate monitor pops and compares against the read ports.
module tb_mips_cpu_hilo_reg;

  localparam logic [31:0] RST_EXP = 32'd0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] data_hi;
  logic [31:0] data_lo;
  logic        hi_en;
  logic        lo_en;
  logic [31:0] read_hi;
  logic [31:0] read_lo;

  exp_t  exp_q[$];
  event  chk_ev;
  int    n_chk  = 0;
  int    n_fail = 0;

  // Reference contents of HI and LO as the architecture defines them.
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mips_cpu_hilo_reg dut (
    .clk     (clk),
    .reset   (reset),
    .data_hi (data_hi),
    .data_lo (data_lo),
    .hi_en   (hi_en),
    .lo_en   (lo_en),
    .read_hi (read_hi),
    .read_lo (read_lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: after each rising edge or an explicit mid-cycle strobe, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (read_hi !== e.hi) begin
          n_fail++;
          $display("FAIL %s read_hi: got %h expected %h", e.tag, read_hi, e.hi);
        end
        n_chk++;
        if (read_lo !== e.lo) begin
          n_fail++;
          $display("FAIL %s read_lo: got %h expected %h", e.tag, read_lo, e.lo);
        end
      end
    end
  end

  // One clock cycle: drive inputs at the falling edge, check the old value
  // mid-cycle (no bypass / immediate reset), then queue the post-edge value.
  task automatic cycle(input bit rst, input bit hen, input bit len,
                       input logic [31:0] dh, input logic [31:0] dl,
                       input string tag);
    @(negedge clk);
    reset   = rst;
    hi_en   = hen;
    lo_en   = len;
    data_hi = dh;
    data_lo = dl;
    if (!rst) begin
      hi_m = RST_EXP;
      lo_m = RST_EXP;
    end
    #2;
    exp_q.push_back('{hi: hi_m, lo: lo_m, tag: {tag, "/pre"}});
    ->chk_ev;
    #2;
    if (rst) begin
      if (hen) hi_m = dh;
      if (len) lo_m = dl;
    end
    exp_q.push_back('{hi: hi_m, lo: lo_m, tag: {tag, "/post"}});
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          r_rst;
    bit          r_hen;
    bit          r_len;
    logic [31:0] r_dh;
    logic [31:0] r_dl;

    reset   = 1'b1;
    hi_en   = 1'b0;
    lo_en   = 1'b0;
    data_hi = 32'd0;
    data_lo = 32'd0;
    hi_m    = RST_EXP;
    lo_m    = RST_EXP;

    // Async reset with no clock edge involved.
    #1 reset = 1'b0;
    #1;
    exp_q.push_back('{hi: RST_EXP, lo: RST_EXP, tag: "reset_async"});
    ->chk_ev;

    // Held reset ignores writes; release leaves outputs at zero.
    cycle(1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, "reset_hold");
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "reset_release");

    // Directed sequence.
    cycle(1'b1, 1'b1, 1'b1, 32'd100, 32'd200, "dual_write");
    cycle(1'b1, 1'b0, 1'b0, 32'd7, 32'd9, "hold1");
    cycle(1'b1, 1'b0, 1'b0, 32'd7, 32'd9, "hold2");
    cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd5, "indep_hi");
    cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, "no_bypass_lo");
    cycle(1'b1, 1'b0, 1'b0, 32'hx, 32'hx, "hold_x_data");
    cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, "mid_reset1");
    cycle(1'b0, 1'b1, 1'b1, 32'h5555_5555, 32'hAAAA_AAAA, "mid_reset2");
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, "first_after_reset");

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      r_rst = ($urandom_range(15) != 0);
      r_hen = $urandom_range(1) != 0;
      r_len = $urandom_range(1) != 0;
      r_dh  = $urandom;
      r_dl  = $urandom;
      if (!r_hen && $urandom_range(1) != 0) r_dh = 32'hx;
      if (!r_len && $urandom_range(1) != 0) r_dl = 32'hx;
      cycle(r_rst, r_hen, r_len, r_dh, r_dl, $sformatf("rand%0d", i));
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mips_cpu_hilo_reg
